reg_transfer_ctrl: RTL and testbench

REG_TRANSFER_CTRL -- requirements
Module: reg_transfer_ctrl

---
 rtl/reg_transfer_ctrl_if.sv | 35 +++
 rtl/reg_transfer_ctrl.sv | 157 +++++++++++++++
 tb/tb_reg_transfer_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_transfer_ctrl_if.sv
// Handshake and data-bus bundle between the transfer controller and its register bank.
// Signals:
//   req, op, src, dst  - transfer request and its operands (op 0 = MOVE, 1 = EXG)
//   bus_a              - shared read bus, driven by the register whose en_a bit is high
//   en_a, en_b, s      - one-hot read enable, write-port enable, store strobe
//   wbus               - write data presented to every register's d input
//   busy, done, err    - status: transfer in progress, completion pulse, request-while-busy pulse
// Modports: master = controller side, slave = requester/register-bank side.
interface reg_transfer_ctrl_if #(
   parameter int W = 32,
   parameter int N = 8
);
   logic         req;
   logic         op;
   logic [2:0]   src;
   logic [2:0]   dst;
   logic [W-1:0] bus_a;
   logic [N-1:0] en_a;
   logic [N-1:0] en_b;
   logic [N-1:0] s;
   logic [W-1:0] wbus;
   logic         busy;
   logic         done;
   logic         err;

   modport master (
      input  req, op, src, dst, bus_a,
      output en_a, en_b, s, wbus, busy, done, err
   );

   modport slave (
      output req, op, src, dst, bus_a,
      input  en_a, en_b, s, wbus, busy, done, err
   );
endinterface

// File: rtl/reg_transfer_ctrl.sv
// Register transfer controller: moves (MOVE) or swaps (EXG) the contents of two
// registers in a bank that shares one read bus and one write bus.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - reg_transfer_ctrl_if.master (request, operands, bus_a in; enables, strobe,
//          wbus, busy/done/err out)
// Parameters: W data width, N number of registers (N <= 8, 3-bit index).
//
// state | meaning
// IDLE  | waiting for req; operands latched on accept
// RD0   | en_a[src] high, bus_a captured into tmp0
// RD1   | EXG only: en_a[dst] high, bus_a captured into tmp1
// WR0   | wbus = tmp0, en_b/s on dst
// WR1   | EXG only: wbus = tmp1, en_b/s on src
// FIN   | done pulse, busy low, back to IDLE
//
// All outputs are registered: each is loaded on the edge that enters the state in
// which it must be visible.
module reg_transfer_ctrl #(
   parameter int W = 32,
   parameter int N = 8
) (
   input logic                clk,
   input logic                rst,
   reg_transfer_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      RD1  = 3'd2,
      WR0  = 3'd3,
      WR1  = 3'd4,
      FIN  = 3'd5
   } state_t;

   state_t       state;
   logic         op_q;
   logic [2:0]   src_q;
   logic [2:0]   dst_q;
   logic [W-1:0] tmp0;
   logic [W-1:0] tmp1;
   logic [N-1:0] en_a_q;
   logic [N-1:0] en_b_q;
   logic [N-1:0] s_q;
   logic [W-1:0] wbus_q;
   logic         busy_q;
   logic         done_q;
   logic         err_q;

   function automatic logic [N-1:0] onehot(input logic [2:0] idx);
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         if (idx == 3'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= 1'b0;
         src_q  <= '0;
         dst_q  <= '0;
         tmp0   <= '0;
         tmp1   <= '0;
         en_a_q <= '0;
         en_b_q <= '0;
         s_q    <= '0;
         wbus_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         en_a_q <= '0;
         en_b_q <= '0;
         s_q    <= '0;
         wbus_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         // A request seen in any state other than IDLE (FIN included) is rejected.
         err_q  <= bus.req && (state != IDLE);
         case (state)
            IDLE: begin
               if (bus.req) begin
                  op_q  <= bus.op;
                  src_q <= bus.src;
                  dst_q <= bus.dst;
                  if (bus.src == bus.dst) begin
                     state  <= FIN;
                     done_q <= 1'b1;
                  end else begin
                     state  <= RD0;
                     en_a_q <= onehot(bus.src);
                     busy_q <= 1'b1;
                  end
               end
            end
            RD0: begin
               tmp0   <= bus.bus_a;
               busy_q <= 1'b1;
               if (op_q) begin
                  state  <= RD1;
                  en_a_q <= onehot(dst_q);
               end else begin
                  // MOVE writes the value being captured right now, so bypass tmp0.
                  state  <= WR0;
                  wbus_q <= bus.bus_a;
                  en_b_q <= onehot(dst_q);
                  s_q    <= onehot(dst_q);
               end
            end
            RD1: begin
               tmp1   <= bus.bus_a;
               state  <= WR0;
               busy_q <= 1'b1;
               wbus_q <= tmp0;
               en_b_q <= onehot(dst_q);
               s_q    <= onehot(dst_q);
            end
            WR0: begin
               if (op_q) begin
                  state  <= WR1;
                  busy_q <= 1'b1;
                  wbus_q <= tmp1;
                  en_b_q <= onehot(src_q);
                  s_q    <= onehot(src_q);
               end else begin
                  state  <= FIN;
                  done_q <= 1'b1;
               end
            end
            WR1: begin
               state  <= FIN;
               done_q <= 1'b1;
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.en_a = en_a_q;
   assign bus.en_b = en_b_q;
   assign bus.s    = s_q;
   assign bus.wbus = wbus_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
module tb_reg_transfer_ctrl;
   localparam int W = 32;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_transfer_ctrl_if #(.W(W), .N(N)) bus ();
   reg_transfer_ctrl #(.W(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   // ---------------- register bank with tri-state read bus ----------------
   logic [W-1:0] regs [N];
   logic         ld_en;
   logic [2:0]   ld_idx;
   logic [W-1:0] ld_val;
   logic [W-1:0] rd_val;

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < N; i++) if (bus.en_a[i]) rd_val = rd_val | regs[i];
   end
   assign bus.bus_a = (bus.en_a == '0) ? {W{1'bz}} : rd_val;

   always @(posedge clk) begin
      if (ld_en) regs[ld_idx] <= ld_val;
      else
         for (int i = 0; i < N; i++)
            if (bus.en_b[i] && bus.s[i]) regs[i] <= bus.wbus;
   end

   // ---------------- scoring ----------------
   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // On accept, the whole visible schedule of the transfer is laid out as a list of
   // per-cycle output records; one record is consumed per clock.
   typedef struct {
      logic [N-1:0] en_a;
      logic [N-1:0] en_b;
      logic [W-1:0] wbus;
      logic         busy;
      logic         done;
   } step_t;

   step_t        q[$];
   step_t        cur;
   logic         cur_v = 1'b0;
   logic         exp_err = 1'b0;
   logic         model_ok = 1'b0;
   logic         regs_valid = 1'b0;
   logic [W-1:0] exp_regs [N];

   function automatic step_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [W-1:0] d, input logic bz, input logic dn);
      step_t t;
      t.en_a = a; t.en_b = b; t.wbus = d; t.busy = bz; t.done = dn;
      return t;
   endfunction

   function automatic logic [N-1:0] bit_of(input logic [2:0] idx);
      logic [N-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   always @(posedge clk) begin
      logic [W-1:0] va, vb;
      if (cur_v)
         for (int i = 0; i < N; i++) if (cur.en_b[i]) exp_regs[i] = cur.wbus;
      if (ld_en) exp_regs[ld_idx] = ld_val;
      if (rst) begin
         q.delete();
         cur_v = 1'b0;
         exp_err = 1'b0;
         model_ok = 1'b1;
      end else begin
         exp_err = bus.req && cur_v;
         if (cur_v) begin
            if (q.size() > 0) cur = q.pop_front();
            else cur_v = 1'b0;
         end else if (bus.req) begin
            va = exp_regs[bus.src];
            vb = exp_regs[bus.dst];
            if (bus.src == bus.dst) begin
               q.push_back(mk('0, '0, '0, 1'b0, 1'b1));
            end else if (bus.op == 1'b0) begin
               q.push_back(mk(bit_of(bus.src), '0, '0, 1'b1, 1'b0));
               q.push_back(mk('0, bit_of(bus.dst), va, 1'b1, 1'b0));
               q.push_back(mk('0, '0, '0, 1'b0, 1'b1));
            end else begin
               q.push_back(mk(bit_of(bus.src), '0, '0, 1'b1, 1'b0));
               q.push_back(mk(bit_of(bus.dst), '0, '0, 1'b1, 1'b0));
               q.push_back(mk('0, bit_of(bus.dst), va, 1'b1, 1'b0));
               q.push_back(mk('0, bit_of(bus.src), vb, 1'b1, 1'b0));
               q.push_back(mk('0, '0, '0, 1'b0, 1'b1));
            end
            cur = q.pop_front();
            cur_v = 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      step_t e;
      if (model_ok) begin
         e = cur_v ? cur : mk('0, '0, '0, 1'b0, 1'b0);
         chk("en_a", 64'(bus.en_a), 64'(e.en_a));
         chk("en_b", 64'(bus.en_b), 64'(e.en_b));
         chk("s", 64'(bus.s), 64'(e.en_b));
         chk("wbus", 64'(bus.wbus), 64'(e.wbus));
         chk("busy", 64'(bus.busy), 64'(e.busy));
         chk("done", 64'(bus.done), 64'(e.done));
         chk("err", 64'(bus.err), 64'(exp_err));
         chk("en_a_onehot0", 64'($onehot0(bus.en_a)), 64'd1);
         chk("en_b_onehot0", 64'($onehot0(bus.en_b)), 64'd1);
         chk("en_a_en_b_both", 64'((|bus.en_a) && (|bus.en_b)), 64'd0);
         chk("s_without_en_b", 64'(|(bus.s & ~bus.en_b)), 64'd0);
         chk("s_outside_write", 64'((|bus.s) && !(cur_v && (|cur.en_b))), 64'd0);
         if (regs_valid)
            for (int i = 0; i < N; i++) chk($sformatf("reg%0d", i), 64'(regs[i]), 64'(exp_regs[i]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic load(input logic [2:0] idx, input logic [W-1:0] val);
      ld_en = 1'b1; ld_idx = idx; ld_val = val;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Called at a negedge. Returns latency from the accept edge to the done cycle,
   // en_a seen in cycle 1 and en_b/s seen in cycle 2.
   task automatic xfer(input logic o, input logic [2:0] sa, input logic [2:0] da,
                       output int lat, output logic [N-1:0] ea1,
                       output logic [N-1:0] eb2, output logic [N-1:0] s2);
      bus.req = 1'b1; bus.op = o; bus.src = sa; bus.dst = da;
      @(negedge clk);
      bus.req = 1'b0; bus.op = ~o; bus.src = da; bus.dst = sa;
      lat = 1; ea1 = bus.en_a; eb2 = '0; s2 = '0;
      while (!bus.done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 2) begin eb2 = bus.en_b; s2 = bus.s; end
      end
      @(negedge clk);
   endtask

   int           lat, errs, dones;
   logic [N-1:0] ea1, eb2, s2;
   logic         busy4;

   initial begin
      rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
      bus.req = 1'b0; bus.op = 1'b0; bus.src = '0; bus.dst = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset en_a", 64'(bus.en_a), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);

      // reset wins over a simultaneous request
      bus.req = 1'b1; bus.src = 3'd1; bus.dst = 3'd2;
      @(negedge clk);
      chk("rst_over_req busy", 64'(bus.busy), 64'd0);
      chk("rst_over_req en_a", 64'(bus.en_a), 64'd0);
      bus.req = 1'b0; rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < N; i++) load(3'(i), 32'h0101_0101 * i);
      load(3'd2, 32'hA5A5_A5A5); load(3'd5, 32'h0);
      load(3'd1, 32'h1111_1111); load(3'd6, 32'h6666_6666);
      load(3'd3, 32'h3333_3333);
      regs_valid = 1'b1;

      // MOVE R2 -> R5
      xfer(1'b0, 3'd2, 3'd5, lat, ea1, eb2, s2);
      chk("move latency", 64'(lat), 64'd3);
      chk("move en_a rd0", 64'(ea1), 64'h04);
      chk("move en_b wr0", 64'(eb2), 64'h20);
      chk("move s wr0", 64'(s2), 64'h20);
      chk("move R5", 64'(regs[5]), 64'hA5A5_A5A5);
      chk("move R2", 64'(regs[2]), 64'hA5A5_A5A5);

      // EXG R1 <-> R6
      xfer(1'b1, 3'd1, 3'd6, lat, ea1, eb2, s2);
      chk("exg latency", 64'(lat), 64'd5);
      chk("exg R1", 64'(regs[1]), 64'h6666_6666);
      chk("exg R6", 64'(regs[6]), 64'h1111_1111);

      // src == dst
      xfer(1'b1, 3'd3, 3'd3, lat, ea1, eb2, s2);
      chk("same latency", 64'(lat), 64'd1);
      chk("same en_a", 64'(ea1), 64'd0);
      chk("same R3", 64'(regs[3]), 64'h3333_3333);

      // req held high through a MOVE R4 -> R0
      load(3'd4, 32'hCAFE_F00D); load(3'd0, 32'h0);
      bus.req = 1'b1; bus.op = 1'b0; bus.src = 3'd4; bus.dst = 3'd0;
      errs = 0; dones = 0; busy4 = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         errs += int'(bus.err); dones += int'(bus.done);
         if (c == 4) busy4 = bus.busy;
      end
      @(negedge clk);
      chk("held req busy after idle", 64'(busy4), 64'd0);
      chk("held req reaccept busy", 64'(bus.busy), 64'd1);
      chk("held req reaccept en_a", 64'(bus.en_a), 64'h10);
      errs += int'(bus.err);
      bus.req = 1'b0;
      for (int c = 0; c < 10 && !bus.done; c++) begin
         @(negedge clk);
         errs += int'(bus.err);
      end
      chk("held req err count", 64'(errs), 64'd3);
      chk("held req first done count", 64'(dones), 64'd1);
      chk("held req second done", 64'(bus.done), 64'd1);
      @(negedge clk);
      chk("held req R0", 64'(regs[0]), 64'hCAFE_F00D);

      // reset in WR0 of an EXG R0 <-> R7
      load(3'd0, 32'h1234_5678); load(3'd7, 32'h9ABC_DEF0);
      bus.req = 1'b1; bus.op = 1'b1; bus.src = 3'd0; bus.dst = 3'd7;
      @(negedge clk);
      bus.req = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort in WR0 s", 64'(bus.s), 64'h80);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", 64'(bus.busy), 64'd0);
      chk("abort en_b", 64'(bus.en_b), 64'd0);
      chk("abort s", 64'(bus.s), 64'd0);
      chk("abort wbus", 64'(bus.wbus), 64'd0);
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         dones += int'(bus.done);
      end
      chk("abort no done", 64'(dones), 64'd0);
      chk("abort R7", 64'(regs[7]), 64'h1234_5678);
      chk("abort R0", 64'(regs[0]), 64'h1234_5678);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
